// File: rtl/cu_pkg.sv
// Shared types for the datapath control unit: FSM states, opcodes, ALU codes
// and instruction classes. Combinational only, no handshaking.
package cu_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_e;

   typedef enum logic [2:0] {
      C_LD, C_LDI, C_ST, C_RTYPE, C_ADDI, C_NOP, C_HALT, C_ILL
   } cls_e;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_ADDI = 5'd7;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   localparam logic [4:0] ALU_ADD = 5'd2;
   localparam logic [4:0] ALU_SUB = 5'd3;
   localparam logic [4:0] ALU_AND = 5'd4;
   localparam logic [4:0] ALU_OR  = 5'd5;
   localparam logic [4:0] ALU_INC = 5'd12;

   function automatic logic [4:0] alu_map(input logic [4:0] op);
      logic [4:0] r;
      r = 5'd0;
      case (op)
         OP_ADD:  r = ALU_ADD;
         OP_SUB:  r = ALU_SUB;
         OP_AND:  r = ALU_AND;
         OP_OR:   r = ALU_OR;
         default: r = 5'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode to instruction class and R-type ALU code; purely combinational,
// zero latency, no flow control.
module cu_decode
   import cu_pkg::*;
#(
   parameter int OPW  = 5,
   parameter int ALUW = 5
) (
   input  logic [OPW-1:0]  op,
   output cls_e            cls,
   output logic [ALUW-1:0] alu
);

   always_comb begin
      cls = C_ILL;
      case (op)
         OP_LD:                          cls = C_LD;
         OP_LDI:                         cls = C_LDI;
         OP_ST:                          cls = C_ST;
         OP_ADD, OP_SUB, OP_AND, OP_OR:  cls = C_RTYPE;
         OP_ADDI:                        cls = C_ADDI;
         OP_NOP:                         cls = C_NOP;
         OP_HALT:                        cls = C_HALT;
         default:                        cls = C_ILL;
      endcase
   end

   assign alu = ALUW'(alu_map(op));

endmodule

// File: rtl/datapath_control_unit.sv
// Moore fetch/decode/execute sequencer driving every datapath strobe; an
// instruction takes 4-8 cycles, stop is honoured only at instruction boundaries.
module datapath_control_unit
   import cu_pkg::*;
#(
   parameter int OPW  = 5,
   parameter int ALUW = 5
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [31:0]     IR,
   input  logic            stop,
   output logic            PCout,
   output logic            Zlowout,
   output logic            MDRout,
   output logic            BAout,
   output logic            Cout,
   output logic            Rout,
   output logic            MARin,
   output logic            Zin,
   output logic            PCin,
   output logic            MDRin,
   output logic            IRin,
   output logic            Yin,
   output logic            Rin,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            Read,
   output logic            Write,
   output logic [ALUW-1:0] ALU_Control,
   output logic            run,
   output logic            illegal
);

   state_e          state_q, state_d, boundary;
   logic            illegal_q, illegal_d;
   logic            undef_t3;
   cls_e            cls;
   logic [ALUW-1:0] rtype_alu;
   logic            ir_unused;

   assign ir_unused = ^IR[31-OPW:0];

   cu_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
      .op  (IR[31 -: OPW]),
      .cls (cls),
      .alu (rtype_alu)
   );

   // IR is stable from T3 onward, so decoding it directly keeps outputs state-driven.
   assign undef_t3 = (state_q == S_T3) && (cls == C_ILL);
   assign boundary = stop ? S_HALT : S_T0;

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q | undef_t3;
      case (state_q)
         S_IDLE: state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3: begin
            case (cls)
               C_HALT:       state_d = S_HALT;
               C_NOP, C_ILL: state_d = boundary;
               default:      state_d = S_T4;
            endcase
         end
         S_T4:   state_d = S_T5;
         S_T5:   state_d = (cls == C_LD || cls == C_ST) ? S_T6 : boundary;
         S_T6:   state_d = (cls == C_LD) ? S_T7 : boundary;
         S_T7:   state_d = boundary;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      {PCout, Zlowout, MDRout, BAout, Cout, Rout} = '0;
      {MARin, Zin, PCin, MDRin, IRin, Yin, Rin}   = '0;
      {Gra, Grb, Grc, Read, Write}                = '0;
      ALU_Control = '0;
      case (state_q)
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; Zin = 1'b1;
            ALU_Control = ALUW'(ALU_INC);
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               C_RTYPE, C_ADDI:   begin Grb = 1'b1; Rout = 1'b1;  Yin = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            Zin = 1'b1;
            if (cls == C_RTYPE) begin
               Grc = 1'b1; Rout = 1'b1; ALU_Control = rtype_alu;
            end else begin
               Cout = 1'b1; ALU_Control = ALUW'(ALU_ADD);
            end
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (cls == C_LD || cls == C_ST) MARin = 1'b1;
            else begin Gra = 1'b1; Rin = 1'b1; end
         end
         S_T6: begin
            MDRin = 1'b1;
            if (cls == C_ST) begin Gra = 1'b1; Rout = 1'b1; Write = 1'b1; end
            else Read = 1'b1;
         end
         S_T7: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
         end
         default: ;
      endcase
   end

   assign run     = (state_q != S_IDLE) && (state_q != S_HALT);
   assign illegal = illegal_q | undef_t3;

   a_one_source: assert property (@(posedge clk) disable iff (clr)
      $onehot0({PCout, Zlowout, MDRout, BAout, Cout, Rout}));
   a_rd_wr: assert property (@(posedge clk) disable iff (clr) !(Read && Write));
   a_alu_idle: assert property (@(posedge clk) disable iff (clr)
      Zin || (ALU_Control == '0));

endmodule

// File: tb/tb_datapath_control_unit.sv
// Random instruction stream against a per-opcode strobe-table model; checks the
// full output word every cycle, including stop, halt, illegal and mid-run clr.
module tb_datapath_control_unit;
   import cu_pkg::*;

   logic clk = 1'b0;
   logic clr, stop;
   logic [31:0] IR;
   logic PCout, Zlowout, MDRout, BAout, Cout, Rout;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
   logic Gra, Grb, Grc, Read, Write;
   logic [4:0] ALU_Control;
   logic run, illegal;

   always #5 clk = ~clk;

   datapath_control_unit #(.OPW(5), .ALUW(5)) dut (
      .clk(clk), .clr(clr), .IR(IR), .stop(stop),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout),
      .Cout(Cout), .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
      .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin), .Gra(Gra),
      .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
      .ALU_Control(ALU_Control), .run(run), .illegal(illegal)
   );

   localparam logic [17:0] S_PCOUT = 18'd1 << 0,  S_ZLOWOUT = 18'd1 << 1;
   localparam logic [17:0] S_MDROUT = 18'd1 << 2, S_BAOUT = 18'd1 << 3;
   localparam logic [17:0] S_COUT = 18'd1 << 4,   S_ROUT = 18'd1 << 5;
   localparam logic [17:0] S_MARIN = 18'd1 << 6,  S_ZIN = 18'd1 << 7;
   localparam logic [17:0] S_PCIN = 18'd1 << 8,   S_MDRIN = 18'd1 << 9;
   localparam logic [17:0] S_IRIN = 18'd1 << 10,  S_YIN = 18'd1 << 11;
   localparam logic [17:0] S_RIN = 18'd1 << 12,   S_GRA = 18'd1 << 13;
   localparam logic [17:0] S_GRB = 18'd1 << 14,   S_GRC = 18'd1 << 15;
   localparam logic [17:0] S_READ = 18'd1 << 16,  S_WRITE = 18'd1 << 17;

   int n_cmp = 0;
   int n_bad = 0;

   logic [24:0] exp_q[$];
   logic        ill;
   logic        to_halt;

   function automatic logic [24:0] obs();
      return {illegal, run, ALU_Control,
              Write, Read, Grc, Grb, Gra, Rin, Yin, IRin, MDRin, PCin, Zin, MARin,
              Rout, Cout, BAout, MDRout, Zlowout, PCout};
   endfunction

   task automatic check_eq(input string tag, input logic [24:0] got, input logic [24:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t got=%h want=%h", tag, $time, got, want);
      end
   endtask

   task automatic push(input logic [17:0] s, input logic [4:0] alu, input logic ia);
      exp_q.push_back({ia, 1'b1, alu, s});
   endtask

   // One entry per cycle of the instruction, straight from the opcode table.
   task automatic push_instr(input logic [4:0] op);
      logic ia;
      ia = ill;
      to_halt = 1'b0;
      push(S_PCOUT | S_MARIN | S_ZIN, 5'd12, ia);
      push(S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 5'd0, ia);
      push(S_MDROUT | S_IRIN, 5'd0, ia);
      case (op)
         5'd0, 5'd1, 5'd2: begin
            push(S_GRB | S_BAOUT | S_YIN, 5'd0, ia);
            push(S_COUT | S_ZIN, 5'd2, ia);
            if (op == 5'd1) push(S_ZLOWOUT | S_GRA | S_RIN, 5'd0, ia);
            else begin
               push(S_ZLOWOUT | S_MARIN, 5'd0, ia);
               if (op == 5'd0) begin
                  push(S_READ | S_MDRIN, 5'd0, ia);
                  push(S_MDROUT | S_GRA | S_RIN, 5'd0, ia);
               end else push(S_GRA | S_ROUT | S_MDRIN | S_WRITE, 5'd0, ia);
            end
         end
         5'd3, 5'd4, 5'd5, 5'd6: begin
            push(S_GRB | S_ROUT | S_YIN, 5'd0, ia);
            push(S_GRC | S_ROUT | S_ZIN, op - 5'd1, ia);
            push(S_ZLOWOUT | S_GRA | S_RIN, 5'd0, ia);
         end
         5'd7: begin
            push(S_GRB | S_ROUT | S_YIN, 5'd0, ia);
            push(S_COUT | S_ZIN, 5'd2, ia);
            push(S_ZLOWOUT | S_GRA | S_RIN, 5'd0, ia);
         end
         5'd26: push(18'd0, 5'd0, ia);
         5'd27: begin push(18'd0, 5'd0, ia); to_halt = 1'b1; end
         default: begin ia = 1'b1; ill = 1'b1; push(18'd0, 5'd0, ia); end
      endcase
   endtask

   task automatic next_ir(input int idx, output logic [31:0] ir);
      logic [31:0] directed[7];
      logic [4:0]  op;
      int          r;
      directed = '{32'h12000090, 32'h00800045, 32'h18000000, 32'h20000000,
                   32'hF8000000, 32'hD0000000, 32'hD8000000};
      if (idx < 7) ir = directed[idx];
      else begin
         r = $urandom_range(0, 15);
         if (r < 8)        op = 5'(r);
         else if (r < 10)  op = 5'd26;
         else if (r == 10) op = 5'd27;
         else if (r < 12)  op = 5'($urandom_range(8, 25));
         else if (r == 12) op = 5'($urandom_range(28, 31));
         else              op = 5'($urandom_range(0, 2));
         ir = {op, 27'($urandom)};
      end
   endtask

   initial begin
      int          rst_left, halt_cnt, n_instr;
      logic        halted, need_new;
      logic [31:0] ir_v;
      logic [24:0] want;
      clr = 1'b1; stop = 1'b0; IR = 32'h0;
      rst_left = 2; halt_cnt = 0; n_instr = 0;
      halted = 1'b0; need_new = 1'b0; ill = 1'b0; to_halt = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (rst_left > 0) begin
            check_eq("idle", obs(), 25'd0);
            rst_left--;
            if (rst_left == 0) begin clr = 1'b0; need_new = 1'b1; end
            continue;
         end
         if (halted) begin
            IR = $urandom;
            check_eq("halt", obs(), {ill, 1'b0, 23'd0});
            halt_cnt--;
            if (halt_cnt == 0) begin
               clr = 1'b1; rst_left = $urandom_range(1, 2);
               ill = 1'b0; halted = 1'b0; exp_q.delete();
            end
            continue;
         end
         if (need_new) begin
            need_new = 1'b0;
            next_ir(n_instr, ir_v);
            n_instr++;
            IR = ir_v;
            push_instr(ir_v[31:27]);
         end
         if (exp_q.size() == 0) begin
            check_eq("model_empty", obs(), 25'h1FFFFFF);
            need_new = 1'b1;
            continue;
         end
         want = exp_q.pop_front();
         check_eq("step", obs(), want);
         stop = ($urandom_range(0, 9) == 0);
         if (n_instr > 7 && $urandom_range(0, 39) == 0) begin
            clr = 1'b1; rst_left = $urandom_range(1, 2);
            ill = 1'b0; exp_q.delete();
         end else if (exp_q.size() == 0) begin
            if (to_halt || stop) begin
               halted = 1'b1; halt_cnt = $urandom_range(1, 4);
            end else need_new = 1'b1;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/datapath_control_unit.md
Name: datapath_control_unit

Overview:
- Moore FSM sequencing the existing multi-bus datapath: fetch, decode, execute.
- Drives every datapath strobe currently hand-driven by benches (PCout, MARin, Gra, BAout, Cout, ALU_Control …).
- Sits beside the datapath.
- Consumes only the IR contents plus run/stop control. One instruction completes per 4–8 cycles.

Parameters:
- OPW, 5, opcode field width (IR[31:27])
- ALUW, 5, ALU_Control width

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous, active-high reset
- IR  in  32  instruction register contents from datapath
- stop  in  1  halt request, sampled at instruction boundary
- PCout, Zlowout, MDRout, BAout, Cout, Rout  out  1 each  bus-source enables
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin  out  1 each  register load enables
- Gra, Grb, Grc  out  1 each  register-field selects
- Read, Write  out  1 each  memory strobes
- ALU_Control  out  ALUW  ALU operation code
- run  out  1  high while executing; low in IDLE/HALT
- illegal  out  1  sticky; set on undefined opcode

Behaviour:
- One clock; reset is synchronous and active-high.
- clr sampled high at posedge → state IDLE and illegal=0, from any state, including mid-instruction.
- Outputs are pure Moore decode of state, so they go to 0 at that same edge.
- A partially executed store with Write already asserted is abandoned.
- IDLE: all strobes 0, ALU_Control=0, run=0. Next state is T0 unconditionally.
- Fetch, all opcodes:
  - T0: PCout, MARin, Zin, ALU_Control=ALU_INC (12).
  - T1: Zlowout, PCin, Read, MDRin. Memory is combinational-read, captured this cycle.
  - T2: MDRout, IRin.
- T3 decodes IR[31:27], valid because IR loaded at end of T2.
- ld (0):
  - T3 Grb, BAout, Yin
  - T4 Cout, ALU_ADD, Zin
  - T5 Zlowout, MARin
  - T6 Read, MDRin
  - T7 MDRout, Gra, Rin
- ldi (1): T3, T4 as ld; T5 Zlowout, Gra, Rin.
- st (2):
  - T3–T5 as ld
  - T6 Gra, Rout, MDRin, Write. Write is high for exactly one cycle.
- R-type add(3), sub(4), and(5), or(6):
  - T3 Grb, Rout, Yin
  - T4 Grc, Rout, Zin, ALU_Control=alu_map(op)
  - T5 Zlowout, Gra, Rin
- addi (7): T3 Grb, Rout, Yin; T4 Cout, ALU_ADD, Zin; T5 Zlowout, Gra, Rin.
- nop (26): T3 is the last state, no strobes.
- halt (27): T3 → HALT. HALT holds all strobes 0 and run=0 until clr.
- Undefined opcode: set illegal, then behave as nop.
- Instruction boundary: after the last state of each instruction, next state is HALT if stop=1, else T0.
- stop is ignored elsewhere. If stop is asserted during T0–T2, the current instruction completes.
- Invariants, checked by assertions:
  - At most one bus source (PCout, Zlowout, MDRout, BAout, Cout, Rout) per cycle.
  - Read and Write never asserted together.
  - ALU_Control=0 whenever Zin=0.
- Cycle counts: ld 8, st 7, ldi/addi/R-type 6, nop 4.

Decomposition:
- Shared package cu_pkg:
  - state enum (IDLE, T0–T7, HALT)
  - opcode constants
  - ALU codes: ALU_ADD=2, ALU_SUB=3, ALU_AND=4, ALU_OR=5, ALU_INC=12
  - instruction-class enum (LD, LDI, ST, RTYPE, ADDI, NOP, HALT, ILL)
- One sub-module, cu_decode: combinational opcode → {class, alu code}.
- The FSM and output decode live in datapath_control_unit.

Test Plan:
- clr=1 for 2 cycles, then 0 → IDLE with all outputs 0, then T0 shows PCout=MARin=Zin=1, ALU_Control=12, run=1.
- IR=0x12000090 (st R4,0x90(R0)) latched at T2 → T6 shows Gra, Rout, MDRin, Write=1 for one cycle; back in T0 7 cycles after previous T0.
- IR=0x00800045 (ld) → T7 shows MDRout, Gra, Rin; T3 uses BAout, not Rout; 8-cycle instruction.
- IR=0x18000000 (add) → T4 shows Grc, Rout, Zin with ALU_Control=2. IR=0x20000000 (sub) → ALU_Control=3.
- stop=1 raised in T1 of an add → add completes T5, then HALT with run=0. IR=0xD8000000 (halt) also → HALT. Only clr exits.
- IR opcode 31 → illegal=1 from T3, stays set across later instructions. clr during T4 of ld → all strobes 0 after the edge, illegal=0, restart T0.
